// File: rtl/fsm_project.sv
// Packet-control FSM for the 1x3 router: sequences header decode, payload
// load, FIFO-full stall and parity handling, and drives the register-stage strobes.
//
// state               | meaning
// DECODE_ADDRESS     0| idle; waiting for a valid header byte
// LOAD_FIRST_DATA    1| header accepted, source stalled for one cycle
// LOAD_DATA          2| streaming payload into the addressed FIFO
// FIFO_FULL_STATE    3| addressed FIFO full, writes stalled
// LOAD_AFTER_FULL    4| resume after stall, write the held byte
// LOAD_PARITY        5| write the parity byte
// CHECK_PARITY_ERROR 6| parity compare in the register stage
// WAIT_TILL_EMPTY    7| destination FIFO still draining a previous packet
module fsm_project (
  input  logic       clockf,
  input  logic       resetnf,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr;
  logic       w_hdr_ok;
  logic       w_empty_hdr;
  logic       w_empty_lat;
  logic       w_soft_lat;

  assign w_hdr_ok = pkt_valid && (data_in != 2'd3);

  // Empty flag of the FIFO named by the incoming header byte.
  always_comb begin
    w_empty_hdr = 1'b0;
    case (data_in)
      2'd0:    w_empty_hdr = fifo_empty_0;
      2'd1:    w_empty_hdr = fifo_empty_1;
      2'd2:    w_empty_hdr = fifo_empty_2;
      default: w_empty_hdr = 1'b0;
    endcase
  end

  // Address 3 is never latched, so its default is unreachable.
  always_comb begin
    w_empty_lat = 1'b0;
    w_soft_lat  = 1'b0;
    case (r_addr)
      2'd0: begin
        w_empty_lat = fifo_empty_0;
        w_soft_lat  = soft_reset_0;
      end
      2'd1: begin
        w_empty_lat = fifo_empty_1;
        w_soft_lat  = soft_reset_1;
      end
      2'd2: begin
        w_empty_lat = fifo_empty_2;
        w_soft_lat  = soft_reset_2;
      end
      default: begin
        w_empty_lat = 1'b0;
        w_soft_lat  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clockf) begin
    if (!resetnf) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= 2'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == DECODE_ADDRESS) && w_hdr_ok)
        r_addr <= data_in;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_soft_lat) begin
      w_next = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS: begin
          if (w_hdr_ok)
            w_next = w_empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: w_next = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)
            w_next = FIFO_FULL_STATE;
          else if (!pkt_valid)
            w_next = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full)
            w_next = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)
            w_next = DECODE_ADDRESS;
          else if (low_pkt_valid)
            w_next = LOAD_PARITY;
          else
            w_next = LOAD_DATA;
        end
        LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (w_empty_lat)
            w_next = LOAD_FIRST_DATA;
        end
        default: w_next = DECODE_ADDRESS;
      endcase
    end
  end

  // Pure Moore decode of the registered state.
  assign detect_add    = (r_state == DECODE_ADDRESS);
  assign lfd_state     = (r_state == LOAD_FIRST_DATA);
  assign ld_state      = (r_state == LOAD_DATA);
  assign laf_state     = (r_state == LOAD_AFTER_FULL);
  assign full_state    = (r_state == FIFO_FULL_STATE);
  assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
  assign write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                         (r_state == LOAD_AFTER_FULL);
  assign busy          = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);
  assign state_out     = r_state;

endmodule

// File: tb/tb_fsm_project.sv
// Bench for fsm_project: directed packet scenarios with literal expectations,
// plus a per-cycle comparison against a behavioural model of the router FSM.
module tb_fsm_project;

  logic       clockf = 1'b0;
  logic       resetnf;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic       write_enb_reg;
  logic       busy;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;

  always #5 clockf = ~clockf;

  fsm_project dut (
    .clockf        (clockf),
    .resetnf       (resetnf),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .busy          (busy),
    .state_out     (state_out)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Behavioural model: state number, latched port, per-state output tables.
  int         m_state = 0;
  int         m_addr  = 0;
  bit         m_valid = 1'b0;
  int         m_next;
  logic [2:0] m_emp, m_sr;
  logic [7:0] busy_tab = 8'b1111_1010;   // busy except states 0 and 2
  logic [7:0] we_tab   = 8'b0011_0100;   // write in states 2, 4, 5

  always @(posedge clockf) begin
    m_emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    m_sr  = {soft_reset_2, soft_reset_1, soft_reset_0};
    if (resetnf === 1'b0) begin
      m_state = 0;
      m_addr  = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_next = m_state;
      if (m_sr[m_addr]) m_next = 0;
      else begin
        case (m_state)
          0: if (pkt_valid && data_in != 2'd3) m_next = m_emp[data_in] ? 1 : 7;
          1: m_next = 2;
          2: if (fifo_full) m_next = 3; else if (!pkt_valid) m_next = 5;
          3: if (!fifo_full) m_next = 4;
          4: m_next = parity_done ? 0 : (low_pkt_valid ? 5 : 2);
          5: m_next = 6;
          6: m_next = fifo_full ? 3 : 0;
          7: if (m_emp[m_addr]) m_next = 1;
          default: m_next = 0;
        endcase
      end
      if (m_state == 0 && pkt_valid && data_in != 2'd3) m_addr = int'(data_in);
      m_state = m_next;
    end
  end

  logic [7:0] exp_out;
  always @(negedge clockf) begin
    if (m_valid) begin
      exp_out = {m_state == 0, m_state == 1, m_state == 2, m_state == 4,
                 m_state == 3, m_state == 6, we_tab[m_state], busy_tab[m_state]};
      chk("model state_out", int'(state_out), m_state);
      chk("model outputs",
          int'({detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, busy}), int'(exp_out));
    end
  end

  task automatic step();
    @(posedge clockf);
    #1;
  endtask

  task automatic expect_state(input string name, input int exp);
    chk(name, int'(state_out), exp);
  endtask

  int seq_norm [8] = '{0, 1, 2, 2, 2, 5, 6, 0};

  initial begin
    resetnf = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    step(); step();
    expect_state("reset state", 0);
    chk("reset detect_add", int'(detect_add), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset write_enb", int'(write_enb_reg), 0);
    resetnf = 1'b1;

    // reset mid-packet
    pkt_valid = 1'b1; data_in = 2'd1;
    step(); step();
    expect_state("pre-reset load_data", 2);
    resetnf = 1'b0; pkt_valid = 1'b0;
    step();
    expect_state("midpkt reset state", 0);
    chk("midpkt reset detect_add", int'(detect_add), 1);
    chk("midpkt reset busy", int'(busy), 0);
    resetnf = 1'b1;
    step();

    // normal packet to port 1
    pkt_valid = 1'b1; data_in = 2'd1;
    expect_state("normal seq", seq_norm[0]);
    for (int i = 1; i < 8; i++) begin
      if (i == 5) pkt_valid = 1'b0;
      step();
      expect_state("normal seq", seq_norm[i]);
      chk("normal write_enb", int'(write_enb_reg),
          (seq_norm[i] == 2 || seq_norm[i] == 5) ? 1 : 0);
    end

    // busy destination on port 2
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_state("wait_till_empty", 7);
      chk("wait busy", int'(busy), 1);
    end
    fifo_empty_2 = 1'b1;
    step(); expect_state("after wait lfd", 1);
    step(); expect_state("after wait ld", 2);
    pkt_valid = 1'b0;
    step(); expect_state("busy-dest parity", 5);
    step(); step(); expect_state("busy-dest done", 0);

    // full stall, then low_pkt_valid -> parity
    pkt_valid = 1'b1; data_in = 2'd0;
    step(); step();
    fifo_full = 1'b1;
    step(); expect_state("full stall", 3);
    chk("full_state strobe", int'(full_state), 1);
    fifo_full = 1'b0;
    step(); expect_state("load after full", 4);
    chk("laf write_enb", int'(write_enb_reg), 1);
    low_pkt_valid = 1'b1;
    step(); expect_state("laf low_pkt -> parity", 5);
    low_pkt_valid = 1'b0; pkt_valid = 1'b0;
    step(); step(); expect_state("stall pkt done", 0);

    // full stall, then parity_done -> decode
    pkt_valid = 1'b1;
    step(); step();
    fifo_full = 1'b1; step();
    fifo_full = 1'b0; step(); expect_state("laf again", 4);
    parity_done = 1'b1; low_pkt_valid = 1'b1;
    step(); expect_state("laf parity_done", 0);
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    // full beats !pkt_valid; soft reset on other port ignored, on latched port honoured
    step(); step();
    fifo_full = 1'b1; pkt_valid = 1'b0;
    step(); expect_state("full wins", 3);
    soft_reset_1 = 1'b1;
    step(); expect_state("foreign soft reset", 3);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    step(); expect_state("own soft reset", 0);
    soft_reset_0 = 1'b0; fifo_full = 1'b0;

    // check_parity with full FIFO
    pkt_valid = 1'b1;
    step(); step();
    pkt_valid = 1'b0;
    step(); expect_state("parity", 5);
    fifo_full = 1'b1;
    step(); expect_state("check parity", 6);
    chk("rst_int_reg", int'(rst_int_reg), 1);
    step(); expect_state("check parity full", 3);
    fifo_full = 1'b0; step();
    parity_done = 1'b1; step(); expect_state("back to decode", 0);
    parity_done = 1'b0;

    // soft reset beats a transition
    pkt_valid = 1'b1; data_in = 2'd2;
    step(); expect_state("lfd port 2", 1);
    soft_reset_2 = 1'b1;
    step(); expect_state("soft beats lfd->ld", 0);

    // soft reset in decode holds state but latch still moves to port 1
    data_in = 2'd1;
    step(); expect_state("decode soft hold", 0);
    soft_reset_2 = 1'b0;
    step(); expect_state("header port 1", 1);
    soft_reset_1 = 1'b1;
    step(); expect_state("latch moved to 1", 0);
    soft_reset_1 = 1'b0;

    // invalid address
    pkt_valid = 1'b1; data_in = 2'd3;
    step(); expect_state("invalid addr", 0);
    step(); expect_state("invalid addr hold", 0);
    pkt_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
